spi_master_tx: RTL

- SPI master that drives one full-duplex frame per request: generates sclk, ss_n and mosi, and captures miso.
- Mode 0: sclk idles low, mosi changes on the falling edge, both ends sample on the rising edge. Data is MSB first.
- Feeds the on-chip oversampling SPI receive slave, or an external SPI slave, from a parallel word supplied by the core logic.
- sclk is derived from the system clock by a programmable divider, so the slave's 3-flop input synchroniser always sees clean edges.

---
 rtl/spi_master_tx.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/spi_master_tx.sv
// Mode-0 SPI master: sends one DATA_WIDTH-bit frame per accepted start, MSB first,
// and captures miso through a 2-flop synchroniser into rx_data.
`timescale 1ns/1ps
module spi_master_tx #(
  parameter int DATA_WIDTH  = 32,
  parameter int HALF_PERIOD = 4,
  parameter int CS_SETUP    = 4,
  parameter int CS_HOLD     = 4,
  parameter int CS_IDLE     = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  sclk,
  output logic                  mosi,
  output logic                  ss_n,
  input  logic                  miso
);

  localparam int MAX_AB  = (HALF_PERIOD > CS_SETUP) ? HALF_PERIOD : CS_SETUP;
  localparam int MAX_CD  = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
  localparam int MAX_CNT = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam int BIT_W   = $clog2(DATA_WIDTH);

  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(CS_IDLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic [BIT_W-1:0]        bit_reg, bit_next;
  logic [DATA_WIDTH-1:0]   tx_shift_reg, tx_shift_next;
  logic [DATA_WIDTH-1:0]   rx_shift_reg, rx_shift_next;
  logic [DATA_WIDTH-1:0]   rx_data_reg, rx_data_next;
  logic                    sclk_reg, sclk_next;
  logic                    mosi_reg, mosi_next;
  logic                    ss_n_reg, ss_n_next;
  logic                    busy_reg, busy_next;
  logic                    done_reg, done_next;
  logic [1:0]              sync_reg;
  logic                    miso_sync;

  assign miso_sync = sync_reg[1];

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], miso};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      bit_reg      <= '0;
      tx_shift_reg <= '0;
      rx_shift_reg <= '0;
      rx_data_reg  <= '0;
      sclk_reg     <= 1'b0;
      mosi_reg     <= 1'b0;
      ss_n_reg     <= 1'b1;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      bit_reg      <= bit_next;
      tx_shift_reg <= tx_shift_next;
      rx_shift_reg <= rx_shift_next;
      rx_data_reg  <= rx_data_next;
      sclk_reg     <= sclk_next;
      mosi_reg     <= mosi_next;
      ss_n_reg     <= ss_n_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg + CNT_W'(1);
    bit_next      = bit_reg;
    tx_shift_next = tx_shift_reg;
    rx_shift_next = rx_shift_reg;
    rx_data_next  = rx_data_reg;
    sclk_next     = sclk_reg;
    mosi_next     = mosi_reg;
    ss_n_next     = ss_n_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (start) begin
          tx_shift_next = tx_data;
          mosi_next     = tx_data[DATA_WIDTH-1];
          ss_n_next     = 1'b0;
          busy_next     = 1'b1;
          state_next    = SETUP;
        end
      end
      SETUP: begin
        if (cnt_reg == SETUP_LAST) begin
          cnt_next   = '0;
          bit_next   = '0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        // Each sclk half-period spans HALF_PERIOD clocks; the phase starts low.
        if (cnt_reg == HALF_LAST) begin
          cnt_next  = '0;
          sclk_next = ~sclk_reg;
          if (!sclk_reg) begin
            rx_shift_next = {rx_shift_reg[DATA_WIDTH-2:0], miso_sync};
          end else if (bit_reg == BIT_LAST) begin
            mosi_next  = 1'b0;
            bit_next   = '0;
            state_next = HOLD;
          end else begin
            tx_shift_next = {tx_shift_reg[DATA_WIDTH-2:0], 1'b0};
            mosi_next     = tx_shift_reg[DATA_WIDTH-2];
            bit_next      = bit_reg + BIT_W'(1);
          end
        end
      end
      HOLD: begin
        if (cnt_reg == HOLD_LAST) begin
          cnt_next     = '0;
          ss_n_next    = 1'b1;
          rx_data_next = rx_shift_reg;
          done_next    = 1'b1;
          state_next   = GAP;
        end
      end
      GAP: begin
        if (cnt_reg == IDLE_LAST) begin
          cnt_next   = '0;
          busy_next  = 1'b0;
          state_next = IDLE;
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign rx_data = rx_data_reg;
  assign sclk    = sclk_reg;
  assign mosi    = mosi_reg;
  assign ss_n    = ss_n_reg;

endmodule
